// File: rtl/arm_pipeline_pkg.sv
// Shared pipeline definitions: widths, NOP encoding, opcode constants, fetch FSM states.
package arm_pipeline_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  // Opcode fields as they sit at the top of the instruction word.
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_t;

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, ID handshake, EX redirect, IF/ID outputs.
interface fetch_stage_if;
  import arm_pipeline_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc,
    input  imem_ready, imem_rdata, id_stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc,
    output imem_ready, imem_rdata, id_stall, branch_taken, branch_target
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO between instruction memory and IF/ID; push and pop may coincide when full.
module fetch_queue #(
  parameter int unsigned Width = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register with stall, redirect and squash of in-flight responses.
// Optional FETCH_BUFFER_EN adds a 2-entry fetch queue so requests continue during ID stalls.
module fetch_stage #(
  parameter int unsigned      PC_W     = arm_pipeline_pkg::PC_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter int unsigned      INSTR_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);
  import arm_pipeline_pkg::*;

  if (INSTR_W != 32) begin : g_instr_w_check
    $error("fetch_stage: INSTR_W must be 32");
  end
  if (PC_W != arm_pipeline_pkg::PC_W) begin : g_pc_w_check
    $error("fetch_stage: PC_W must match arm_pipeline_pkg::PC_W");
  end

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    squash_addr_q, squash_addr_d;
  logic               squash_q, squash_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;

  logic req;
  logic addr_sel_squash;
  logic id_free;
  logic fetch;

  assign id_free         = !bus.id_stall || !if_id_valid_q;
  assign addr_sel_squash = squash_q;
  // A response is usable only if it is not the squashed one and no redirect lands this cycle.
  assign fetch           = req && bus.imem_ready && !squash_q && !bus.branch_taken;

`ifdef FETCH_BUFFER_EN
  logic                    q_full, q_empty, q_push, q_pop, bypass;
  logic [INSTR_W+PC_W-1:0] q_head;

  assign q_pop  = !q_empty && id_free && !bus.branch_taken;
  assign bypass = fetch && q_empty && id_free;
  assign q_push = fetch && !bypass;

  fetch_queue #(
    .Width (INSTR_W + PC_W)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({bus.imem_rdata, pc_q}),
    .pop       (q_pop),
    .flush     (bus.branch_taken),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      squash_q      <= 1'b0;
      squash_addr_q <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      squash_addr_q <= squash_addr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
`ifndef FETCH_BUFFER_EN
        if (!bus.branch_taken && !squash_q && bus.id_stall && if_id_valid_q) state_d = HOLD;
`endif
      end
      HOLD: begin
        // A redirect empties IF/ID, so there is nothing left to hold.
        if (!bus.id_stall || bus.branch_taken) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef FETCH_BUFFER_EN
    req = (state_q == REQ) && (!q_full || q_pop);
`else
    req = (state_q == REQ);
`endif
    bus.imem_req    = req;
    bus.imem_addr   = addr_sel_squash ? squash_addr_q : pc_q;
    bus.if_id_valid = if_id_valid_q;
    bus.if_id_instr = if_id_instr_q;
    bus.if_id_pc    = if_id_pc_q;
  end

  always_comb begin
    pc_d          = pc_q;
    // While squashing, the request address must stay where it was when the redirect arrived.
    squash_addr_d = bus.imem_addr;
    squash_d      = req && !bus.imem_ready && (squash_q || bus.branch_taken);
    if_id_valid_d = 1'b0;
    if_id_instr_d = NOP_INSTR;
    if_id_pc_d    = if_id_pc_q;

    if (bus.branch_taken) begin
      pc_d = bus.branch_target;
    end else if (fetch) begin
`ifdef FETCH_BUFFER_EN
      pc_d = next_pc(pc_q);
`else
      if (id_free) pc_d = next_pc(pc_q);
`endif
    end

    if (!bus.branch_taken) begin
`ifdef FETCH_BUFFER_EN
      if (q_pop) begin
        if_id_valid_d = 1'b1;
        {if_id_instr_d, if_id_pc_d} = q_head;
      end else if (bypass) begin
        if_id_valid_d = 1'b1;
        if_id_instr_d = bus.imem_rdata;
        if_id_pc_d    = pc_q;
      end else
`else
      if (fetch && id_free) begin
        if_id_valid_d = 1'b1;
        if_id_instr_d = bus.imem_rdata;
        if_id_pc_d    = pc_q;
      end else
`endif
      if (bus.id_stall && if_id_valid_q) begin
        if_id_valid_d = 1'b1;
        if_id_instr_d = if_id_instr_q;
      end
    end
  end

endmodule
